state_dwell_timer: RTL and testbench

//  Parametrised per-state dwell timer for the train controller FSM. Watches present_state,

---
 rtl/train_ctrl_pkg.sv | 32 +++
 rtl/ms_tick_gen.sv | 36 +++
 rtl/state_dwell_timer.sv | 108 ++++++++++
 tb/tb_state_dwell_timer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/train_ctrl_pkg.sv
// Shared train controller definitions: state encodings, dwell widths and
// the default per-state dwell table.
package train_ctrl_pkg;

    localparam int unsigned DWELL_STATE_W = 4;
    localparam int unsigned DWELL_T_W     = 19;

    localparam logic [3:0] ST_IDLE        = 4'd0;
    localparam logic [3:0] ST_READY       = 4'd1;
    localparam logic [3:0] ST_ACCEL       = 4'd2;
    localparam logic [3:0] ST_DOORS_OPEN  = 4'd3;
    localparam logic [3:0] ST_DOORS_CLOSE = 4'd4;
    localparam logic [3:0] ST_DEPART      = 4'd5;
    localparam logic [3:0] ST_CRUISE      = 4'd6;
    localparam logic [3:0] ST_BRAKE       = 4'd7;

    localparam int unsigned DWELL_ST3_MS = 1000;
    localparam int unsigned DWELL_ST4_MS = 2000;
    localparam int unsigned DWELL_ST5_MS = 2000;

    function automatic int unsigned dwell_default_ms(input int unsigned st);
        int unsigned r;
        unique case (1'b1)
            st == 32'(ST_DOORS_OPEN):  r = DWELL_ST3_MS;
            st == 32'(ST_DOORS_CLOSE): r = DWELL_ST4_MS;
            st == 32'(ST_DEPART):      r = DWELL_ST5_MS;
            default:                   r = 0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every TICK_DIV enabled cycles.
module ms_tick_gen #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = enable && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/state_dwell_timer.sv
// Per-state dwell timer for the train controller FSM.
// Define DWELL_CFG_EN to make the duration table runtime-writable.
module state_dwell_timer
    import train_ctrl_pkg::*;
#(
    parameter int unsigned STATE_W  = DWELL_STATE_W,
    parameter int unsigned T_W      = DWELL_T_W,
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STATE_W-1:0] present_state,
    input  logic               hold,
    input  logic               cfg_we,
    input  logic [STATE_W-1:0] cfg_addr,
    input  logic [T_W-1:0]     cfg_data,
    output logic [T_W-1:0]     t,
    output logic [T_W-1:0]     remaining,
    output logic               busy,
    output logic               expired
);

    localparam int unsigned N = 2 ** STATE_W;

    logic [STATE_W-1:0] prev_q;
    logic [T_W-1:0]     t_q, t_d;
    logic [T_W-1:0]     rem_q, rem_d;
    logic               busy_q, busy_d;
    logic               exp_q, exp_d;
    logic [T_W-1:0]     dur;
    logic               entry;
    logic               tick;

`ifdef DWELL_CFG_EN
    logic [T_W-1:0] tab_q [N];

    // Read is combinational off the old contents, so a same-edge write
    // to the entered state only takes effect on the following entry.
    assign dur = tab_q[present_state];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                tab_q[i] <= T_W'(dwell_default_ms(i));
            end
        end else if (cfg_we) begin
            tab_q[cfg_addr] <= cfg_data;
        end
    end
`else
    logic cfg_unused;

    assign dur        = T_W'(dwell_default_ms(32'(present_state)));
    assign cfg_unused = ^{cfg_we, cfg_addr, cfg_data};
`endif

    assign entry = (present_state != prev_q);

    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clear  (entry),
        .enable (busy_q && !hold),
        .tick   (tick)
    );

    always_comb begin
        t_d    = t_q;
        rem_d  = rem_q;
        busy_d = busy_q;
        exp_d  = 1'b0;
        if (entry) begin
            t_d    = dur;
            rem_d  = dur;
            busy_d = (dur != '0);
        end else if (tick && (rem_q != '0)) begin
            rem_d = rem_q - 1'b1;
            if (rem_q == T_W'(1)) begin
                busy_d = 1'b0;
                exp_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
            t_q    <= '0;
            rem_q  <= '0;
            busy_q <= 1'b0;
            exp_q  <= 1'b0;
        end else begin
            prev_q <= present_state;
            t_q    <= t_d;
            rem_q  <= rem_d;
            busy_q <= busy_d;
            exp_q  <= exp_d;
        end
    end

    assign t         = t_q;
    assign remaining = rem_q;
    assign busy      = busy_q;
    assign expired   = exp_q;

endmodule

// File: tb/tb_state_dwell_timer.sv
// Testbench for state_dwell_timer: vector table, corner sequences and
// randomized traffic against an elapsed-time reference model.
module tb_state_dwell_timer;

    localparam int SW = 4;
    localparam int TW = 19;
`ifdef DWELL_CFG_EN
    localparam bit CFG_EN = 1'b1;
`else
    localparam bit CFG_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [SW-1:0] ps = '0;
    logic          hold = 1'b0;
    logic          cfg_we = 1'b0;
    logic [SW-1:0] cfg_addr = '0;
    logic [TW-1:0] cfg_data = '0;
    logic [TW-1:0] t, rem;
    logic          busy, expired;

    logic          rst4 = 1'b1;
    logic [SW-1:0] ps4 = '0;
    logic          hold4 = 1'b0;
    logic          cfg_we4 = 1'b0;
    logic [SW-1:0] cfg_addr4 = '0;
    logic [TW-1:0] cfg_data4 = '0;
    logic [TW-1:0] t4, rem4;
    logic          busy4, exp4;

    always #5 clk = ~clk;

    state_dwell_timer #(.STATE_W(SW), .T_W(TW), .TICK_DIV(1)) dut (
        .clk(clk), .rst(rst), .present_state(ps), .hold(hold),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .t(t), .remaining(rem), .busy(busy), .expired(expired)
    );

    state_dwell_timer #(.STATE_W(SW), .T_W(TW), .TICK_DIV(4)) dut4 (
        .clk(clk), .rst(rst4), .present_state(ps4), .hold(hold4),
        .cfg_we(cfg_we4), .cfg_addr(cfg_addr4), .cfg_data(cfg_data4),
        .t(t4), .remaining(rem4), .busy(busy4), .expired(exp4)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned spec_default(input int s);
        if (s == 3) return 1000;
        if (s == 4 || s == 5) return 2000;
        return 0;
    endfunction

    // Model: a dwell is a duration plus the number of unheld cycles since entry.
    logic [TW-1:0] m_tab [16];
    logic [SW-1:0] m_prev;
    int unsigned   m_dur;
    int unsigned   m_el;
    logic          m_exp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) m_tab[i] <= TW'(spec_default(i));
            m_prev <= '0;
            m_dur  <= 0;
            m_el   <= 0;
            m_exp  <= 1'b0;
        end else begin
            if (ps != m_prev) begin
                m_dur <= 32'(m_tab[ps]);
                m_el  <= 0;
                m_exp <= 1'b0;
            end else if (!hold && m_el < m_dur) begin
                m_el  <= m_el + 1;
                m_exp <= (m_el + 1 == m_dur);
            end else begin
                m_exp <= 1'b0;
            end
            m_prev <= ps;
`ifdef DWELL_CFG_EN
            if (cfg_we) m_tab[cfg_addr] <= cfg_data;
`endif
        end
    end

    typedef struct {
        logic [SW-1:0] st;
        logic          hd;
        int            n;
        int            t;
        int            rem;
        logic          bsy;
        int            pulses;
    } vec_t;

    vec_t vecs[15];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pulses;

        vecs[0]  = '{4'd3, 1'b0,    1, 1000, 1000, 1'b1, 0};
        vecs[1]  = '{4'd3, 1'b0,   10, 1000,  990, 1'b1, 0};
        vecs[2]  = '{4'd3, 1'b1,   50, 1000,  990, 1'b1, 0};
        vecs[3]  = '{4'd3, 1'b0,  989, 1000,    1, 1'b1, 0};
        vecs[4]  = '{4'd3, 1'b0,    1, 1000,    0, 1'b0, 1};
        vecs[5]  = '{4'd3, 1'b0,    1, 1000,    0, 1'b0, 0};
        vecs[6]  = '{4'd7, 1'b0,    1,    0,    0, 1'b0, 0};
        vecs[7]  = '{4'd4, 1'b0,    1, 2000, 2000, 1'b1, 0};
        vecs[8]  = '{4'd4, 1'b1,    5, 2000, 2000, 1'b1, 0};
        vecs[9]  = '{4'd4, 1'b0,  100, 2000, 1900, 1'b1, 0};
        vecs[10] = '{4'd5, 1'b0,    1, 2000, 2000, 1'b1, 0};
        vecs[11] = '{4'd5, 1'b0, 1999, 2000,    1, 1'b1, 0};
        vecs[12] = '{4'd3, 1'b0,    1, 1000, 1000, 1'b1, 0};
        vecs[13] = '{4'd3, 1'b0, 1000, 1000,    0, 1'b0, 1};
        vecs[14] = '{4'd0, 1'b0,    1,    0,    0, 1'b0, 0};

        repeat (3) step();
        chk("reset_t", 32'(t), 0);
        chk("reset_rem", 32'(rem), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_exp", 32'(expired), 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 15; i++) begin
            ps = vecs[i].st;
            hold = vecs[i].hd;
            pulses = 0;
            repeat (vecs[i].n) begin
                step();
                if (expired) pulses++;
            end
            chk($sformatf("vec%0d_t", i), 32'(t), vecs[i].t);
            chk($sformatf("vec%0d_rem", i), 32'(rem), vecs[i].rem);
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].bsy));
            chk($sformatf("vec%0d_pulses", i), pulses, vecs[i].pulses);
        end
        hold = 1'b0;

        ps = 4'd3;
        step();
        n = 0;
        while (!expired && n < 1200) begin
            step();
            n++;
        end
        chk("lat_st3", n, 1000);

        ps = 4'd4;
        step();
        repeat (500) step();
        hold = 1'b1;
        repeat (50) step();
        chk("hold_rem", 32'(rem), 1500);
        chk("hold_exp", 32'(expired), 0);
        hold = 1'b0;
        n = 550;
        while (!expired && n < 3000) begin
            step();
            n++;
        end
        chk("lat_st4_hold", n, 2050);

        ps = 4'd7;
        step();
        pulses = 0;
        repeat (5000) begin
            step();
            if (expired) pulses++;
        end
        chk("st7_pulses", pulses, 0);
        chk("st7_busy", 32'(busy), 0);
        chk("st7_rem", 32'(rem), 0);

        rst = 1'b1;
        step();
        ps = 4'd4;
        step();
        chk("rst_held_t", 32'(t), 0);
        rst = 1'b0;
        step();
        chk("rst_exit_t", 32'(t), 2000);
        chk("rst_exit_rem", 32'(rem), 2000);

        ps = 4'd0;
        step();
        ps = 4'd3;
        step();
        cfg_we = 1'b1;
        cfg_addr = 4'd3;
        cfg_data = 19'd10;
        step();
        cfg_we = 1'b0;
        chk("cfg_cur_t", 32'(t), 1000);
        chk("cfg_cur_rem", 32'(rem), 999);
        ps = 4'd0;
        step();
        ps = 4'd3;
        step();
        chk("cfg_reentry_t", 32'(t), CFG_EN ? 10 : 1000);
        n = 0;
        while (!expired && n < 1200) begin
            step();
            n++;
        end
        chk("cfg_reentry_lat", n, CFG_EN ? 10 : 1000);

        ps = 4'd0;
        step();
        cfg_we = 1'b1;
        cfg_addr = 4'd4;
        cfg_data = 19'd7;
        ps = 4'd4;
        step();
        cfg_we = 1'b0;
        chk("cfg_same_edge_t", 32'(t), 2000);
        ps = 4'd0;
        step();
        ps = 4'd4;
        step();
        chk("cfg_next_entry_t", 32'(t), CFG_EN ? 7 : 2000);

        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            int k;
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 99) < 3) begin
                k = $urandom_range(0, 6);
                ps = (k == 6) ? 4'd9 : ((k == 2) ? 4'd7 : SW'(k + 1));
            end
            hold = ($urandom_range(0, 3) == 0);
            cfg_we = ($urandom_range(0, 19) == 0);
            cfg_addr = SW'($urandom_range(0, 15));
            cfg_data = TW'($urandom_range(1, 30));
            step();
            chk("rnd_t", 32'(t), m_dur);
            chk("rnd_rem", 32'(rem), m_dur - m_el);
            chk("rnd_busy", 32'(busy), 32'(m_dur != m_el));
            chk("rnd_exp", 32'(expired), 32'(m_exp));
        end
        rst = 1'b0;
        hold = 1'b0;
        cfg_we = 1'b0;

        rst4 = 1'b0;
        cfg_we4 = 1'b1;
        cfg_addr4 = 4'd3;
        cfg_data4 = 19'd2;
        step();
        cfg_we4 = 1'b0;
        ps4 = 4'd3;
        step();
        n = 0;
        while (!exp4 && n < 5000) begin
            step();
            n++;
        end
        chk("div4_lat", n, CFG_EN ? 8 : 4000);
        ps4 = 4'd0;
        step();
        ps4 = 4'd3;
        step();
        repeat (3) step();
        chk("div4_busy_pre", 32'(busy4), 1);
        rst4 = 1'b1;
        #1;
        chk("div4_rst_t", 32'(t4), 0);
        chk("div4_rst_rem", 32'(rem4), 0);
        chk("div4_rst_busy", 32'(busy4), 0);
        chk("div4_rst_exp", 32'(exp4), 0);
        step();
        rst4 = 1'b0;
        step();
        chk("div4_table_restored", 32'(t4), 1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
